// File: rtl/mod3_serial_tx.sv
// mod3_serial_tx
// Serial transmitter for residue-coded frames. A DATA_W-bit payload is
// shifted out MSB-first, followed by a 2-bit check field chosen so that
// the whole (DATA_W+2)-bit frame, read as an unsigned number, is a
// multiple of 3. The downstream serial remainder-by-3 detector therefore
// sees "divisible" on the last check bit of every correct frame.
//
// Frame timing (one bit per clock, all outputs registered):
//   edge 0        : start accepted in IDLE, payload captured
//   cycles 1..W   : payload bits, MSB first          (state DATA)
//   cycle  W+1    : check bit c[1]                   (state CHK1)
//   cycle  W+2    : check bit c[0], frame_done = 1   (state CHK0)
//   cycle  W+3    : mandatory IDLE cycle, start may be accepted here
//
// Check arithmetic: 4 == 1 (mod 3), so data*4 + c == data + c (mod 3).
// Choosing c = (3 - data mod 3) mod 3 makes the frame divisible by 3:
//   residue 0 -> 2'b00, residue 1 -> 2'b10, residue 2 -> 2'b01.
// The check field 2'b11 is never produced.

module mod3_serial_tx #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_ser_out,
  output logic              o_ser_valid,
  output logic              o_frame_done
);

  // Counter wide enough to hold DATA_W-1 (the index of the MSB).
  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  // The state names what is currently on o_ser_out, because every output
  // is registered alongside the state transition that produces it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CHK1 = 2'd2,
    ST_CHK0 = 2'd3
  } state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_shift;    // payload bits not yet emitted, MSB-aligned
  logic [CNT_W-1:0]   r_cnt;      // bit index of the payload bit now on o_ser_out
  logic [1:0]         r_residue;  // value of the emitted prefix mod 3, always 0..2
  logic [1:0]         r_chk;      // check field held for the two CHK cycles

  // Residue of a prefix after appending one bit: (2r + b) mod 3, kept in
  // three states so the value 3 can never appear.
  function automatic logic [1:0] residue_step(input logic [1:0] r, input logic b);
    logic [1:0] n;
    case (r)
      2'd0:    n = b ? 2'd1 : 2'd0;   // 0 + b
      2'd1:    n = b ? 2'd0 : 2'd2;   // 2 + b
      2'd2:    n = b ? 2'd2 : 2'd1;   // 4 + b
      default: n = 2'd0;              // unreachable encoding, recover to 0
    endcase
    return n;
  endfunction

  // Check field that completes a payload of residue r to a multiple of 3.
  function automatic logic [1:0] check_code(input logic [1:0] r);
    logic [1:0] c;
    case (r)
      2'd0:    c = 2'b00;
      2'd1:    c = 2'b10;
      2'd2:    c = 2'b01;
      default: c = 2'b00;
    endcase
    return c;
  endfunction

  logic [1:0] w_residue_next;
  assign w_residue_next = residue_step(r_residue, o_ser_out);

  // Frame sequencer: state, datapath and registered outputs in one process.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would let later statements see
  // half-updated state and make the result depend on statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // A reset mid-frame simply drops the frame; no frame_done is emitted.
      // The shift register is cleared too so no stale payload survives a
      // reset, even though it is reloaded on every accepted start.
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_residue    <= 2'd0;
      r_chk        <= 2'b00;
      o_busy       <= 1'b0;
      o_ser_out    <= 1'b0;
      o_ser_valid  <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_frame_done <= 1'b0;
          if (i_start) begin
            // MSB goes straight to the output; the rest waits in r_shift.
            r_shift     <= {i_data_in[DATA_W-2:0], 1'b0};
            r_cnt       <= CNT_W'(DATA_W - 1);
            r_residue   <= 2'd0;
            o_ser_out   <= i_data_in[DATA_W-1];
            o_ser_valid <= 1'b1;
            o_busy      <= 1'b1;
            r_state     <= ST_DATA;
          end else begin
            o_ser_out   <= 1'b0;
            o_ser_valid <= 1'b0;
            o_busy      <= 1'b0;
          end
        end

        ST_DATA: begin
          // Fold the bit on the wire this cycle into the running residue.
          r_residue <= w_residue_next;
          if (r_cnt == '0) begin
            // The LSB is on the wire: the residue now covers the whole
            // payload, so the check field is known.
            r_chk     <= check_code(w_residue_next);
            o_ser_out <= check_code(w_residue_next) >> 1;
            r_state   <= ST_CHK1;
          end else begin
            o_ser_out <= r_shift[DATA_W-1];
            r_shift   <= r_shift << 1;
            r_cnt     <= r_cnt - CNT_W'(1);
          end
        end

        ST_CHK1: begin
          o_ser_out    <= r_chk[0];
          o_frame_done <= 1'b1;
          r_state      <= ST_CHK0;
        end

        ST_CHK0: begin
          // start is ignored here; the IDLE cycle that follows is mandatory.
          o_ser_out    <= 1'b0;
          o_ser_valid  <= 1'b0;
          o_busy       <= 1'b0;
          o_frame_done <= 1'b0;
          r_state      <= ST_IDLE;
        end

        default: begin
          r_state      <= ST_IDLE;
          o_ser_out    <= 1'b0;
          o_ser_valid  <= 1'b0;
          o_busy       <= 1'b0;
          o_frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod3_serial_tx.sv
// Testbench for mod3_serial_tx (DATA_W = 8).
// Directed vectors come from a table of {payload, expected frame} records;
// random payloads are checked against an arithmetic frame model and a
// behavioural serial remainder-by-3 checker fed from ser_out.

module tb_mod3_serial_tx;

  localparam int DATA_W  = 8;
  localparam int FRAME_W = DATA_W + 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              start = 1'b0;
  logic              busy;
  logic              ser_out;
  logic              ser_valid;
  logic              frame_done;

  int n_checks = 0;
  int n_errors = 0;

  mod3_serial_tx #(.DATA_W(DATA_W)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data_in    (data_in),
    .i_start      (start),
    .o_busy       (busy),
    .o_ser_out    (ser_out),
    .o_ser_valid  (ser_valid),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic [DATA_W-1:0]  data;
    logic [FRAME_W-1:0] frame;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs and samples both sit 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame value from the arithmetic rule: data*4 + (3 - data mod 3) mod 3.
  function automatic logic [FRAME_W-1:0] model_frame(input logic [DATA_W-1:0] d);
    int v;
    v = int'(d);
    return FRAME_W'(v * 4 + (3 - v % 3) % 3);
  endfunction

  task automatic check_idle(input string name);
    check({name, ".busy"},       32'(busy),       32'd0);
    check({name, ".ser_valid"},  32'(ser_valid),  32'd0);
    check({name, ".frame_done"}, 32'(frame_done), 32'd0);
    check({name, ".ser_out"},    32'(ser_out),    32'd0);
  endtask

  // Collect one frame whose first bit is on the wire now. start is left as
  // the caller set it; data_in is scrambled each cycle to prove it is not
  // re-sampled. The serial remainder checker restarts at each frame.
  task automatic collect_frame(input string name, output logic [FRAME_W-1:0] got);
    int rem;
    got = '0;
    rem = 0;
    for (int i = 0; i < FRAME_W; i++) begin
      check({name, ".ser_valid"},  32'(ser_valid),  32'd1);
      check({name, ".busy"},       32'(busy),       32'd1);
      check({name, ".frame_done"}, 32'(frame_done), 32'(i == FRAME_W - 1));
      got = {got[FRAME_W-2:0], ser_out};
      rem = (rem * 2 + int'(ser_out)) % 3;
      if (i == FRAME_W - 1) check({name, ".divisible"}, 32'(rem), 32'd0);
      data_in = DATA_W'($urandom);
      tick();
    end
  endtask

  task automatic run_frame(input string name, input logic [DATA_W-1:0] d,
                           input logic [FRAME_W-1:0] exp);
    logic [FRAME_W-1:0] got;
    data_in = d;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    collect_frame(name, got);
    check({name, ".frame"},   32'(got), 32'(exp));
    check({name, ".chk!=11"}, 32'(got[1:0] == 2'b11), 32'd0);
    check_idle({name, ".after"});
  endtask

  initial begin
    logic [FRAME_W-1:0] got;
    logic [DATA_W-1:0]  d;

    vecs[0] = '{name: "d05", data: 8'h05, frame: 10'd21};
    vecs[1] = '{name: "d07", data: 8'h07, frame: 10'd30};
    vecs[2] = '{name: "dFF", data: 8'hFF, frame: 10'd1020};
    vecs[3] = '{name: "d00", data: 8'h00, frame: 10'd0};

    // Reset, then five idle cycles with every output low.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_idle("reset_idle");
      tick();
    end

    // Directed vectors from the table.
    foreach (vecs[i]) run_frame(vecs[i].name, vecs[i].data, vecs[i].frame);

    // start held high: back-to-back frames with one IDLE cycle between them.
    data_in = 8'h05;
    start   = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      collect_frame("held_start", got);
      data_in = 8'h05;
      check("held_start.frame", 32'(got), 32'd21);
      check_idle("held_start.gap");
      if (f == 2) start = 1'b0;
      tick();
    end
    check_idle("held_start.end");

    // Reset on the 4th bit of a frame aborts it silently.
    data_in = 8'h05;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("abort.valid_before", 32'(ser_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("abort.after_rst");
    for (int i = 0; i < FRAME_W; i++) begin
      check("abort.no_done",  32'(frame_done), 32'd0);
      check("abort.no_valid", 32'(ser_valid),  32'd0);
      tick();
    end
    run_frame("abort.next", 8'h07, 10'd30);

    // rst and start on the same edge: reset wins, nothing is accepted.
    data_in = 8'hA5;
    start   = 1'b1;
    rst     = 1'b1;
    tick();
    rst     = 1'b0;
    start   = 1'b0;
    check_idle("rst_start.edge");
    tick();
    check_idle("rst_start.next");

    // Randomised loopback against the arithmetic model.
    for (int n = 0; n < 200; n++) begin
      d = DATA_W'($urandom);
      run_frame("random", d, model_frame(d));
      // Random idle gap of 0..2 extra cycles on top of the mandatory one.
      for (int g = 0; g < int'($urandom_range(2, 0)); g++) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mod3_serial_tx.md
Name: mod3_serial_tx

Overview:
- Serial transmitter that produces residue-coded bit streams for the team's serial mod-3 checkers.
- Accepts a DATA_W-bit parallel word and shifts it out MSB-first, one bit per clock.
- Appends a 2-bit check field so the whole (DATA_W+2)-bit frame, read as an unsigned number, is divisible by 3.
- Sits upstream of the serial remainder-by-3 detector; a correct frame drives that detector's "divisible" indication high on the last check bit.

Parameters:
DATA_W, 8, payload width in bits (legal 2..32)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; synchronous and active-high, one clock
data_in  input  DATA_W  payload word; sampled only on the accepting edge
start  input  1  load request; honoured only when busy=0
busy  output  1  high from the cycle after acceptance through the last check bit
ser_out  output  1  serial bit, MSB-first; meaningful only while ser_valid=1
ser_valid  output  1  high exactly during the DATA_W+2 frame bit cycles
frame_done  output  1  one-cycle pulse coincident with the last check bit

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE; busy, ser_out, ser_valid and frame_done go to 0.
  - Shift register, bit counter and residue go to 0.
  - Reset mid-frame aborts the frame silently; no frame_done is produced.
- All outputs are registered, so there is no combinational path from start or data_in to any output.
- State machine (IDLE, DATA, CHK1, CHK0):
  - IDLE: on a clock edge with start=1:
    - load data_in into the shift register, clear the residue, set the counter to DATA_W-1, and enter DATA;
    - ser_out = data_in[DATA_W-1], ser_valid=1, busy=1 in the following cycle.
    - start=0 keeps the block in IDLE with outputs low.
  - DATA: each edge emits the next lower data bit.
    - Residue is updated per emitted bit as r <= (2r + bit) mod 3, using 3-valued state {0,1,2} in 2 bits; value 3 is never reached.
    - After the LSB cycle, go to CHK1 with check c = (3 - r_final) mod 3, where r_final = data_in mod 3.
  - CHK1: ser_out = c[1].
  - CHK0: ser_out = c[0], frame_done=1. Next edge returns to IDLE and busy, ser_valid, frame_done drop to 0.
- Check arithmetic: 4 ≡ 1 (mod 3), so frame value = data*4 + c ≡ data + c ≡ 0 (mod 3). The valid codes are:
  - residue 0 -> check 00
  - residue 1 -> check 10
  - residue 2 -> check 01
  - The check field is never 11.
- Latency and throughput:
  - First bit appears one cycle after the accepting edge.
  - Frame length is exactly DATA_W+2 cycles.
  - Minimum spacing between frame starts is DATA_W+3 cycles, because one IDLE cycle is mandatory.
- start while busy=1, including the frame_done cycle, is ignored and not queued.
- data_in changes after acceptance have no effect on the frame in flight.
- rst and start asserted on the same edge: reset wins and the block stays in IDLE.
- DATA_W boundary values: all-zeros and all-ones payloads must encode correctly (all-ones has residue 0 for even DATA_W and residue 1 for odd DATA_W).

Test Plan:
- Reset, then idle for 5 cycles -> busy=ser_valid=frame_done=ser_out=0 throughout.
- DATA_W=8, data_in=0x05 (residue 2), start pulse -> ser_out over 10 valid cycles = 0,0,0,0,0,1,0,1,0,1 (value 21); frame_done only on the 10th cycle; busy low on the 11th.
- data_in=0x07 (residue 1) -> check bits 1,0 (value 30). data_in=0xFF -> check 0,0. data_in=0x00 -> 10 zero bits with ser_valid=1 for 10 cycles.
- Hold start=1 continuously with data_in=0x05 -> frames separated by exactly one idle cycle (11-cycle period); start during a frame never restarts or corrupts it.
- Assert rst on the 4th bit of a frame -> next cycle all outputs 0, no frame_done; a subsequent start with 0x07 produces a correct frame.
- Randomised loopback: feed ser_out into the serial remainder-by-3 checker, reset at each frame start, across 200 random words -> checker reports divisible on every last check bit; frame bits reassembled MSB-first equal {data_in, c} with c ≠ 11.
